// File: rtl/fetch_decode_queue.sv
// First-word-fall-through {pc, instruction} queue between fetch and decode, flushed on pc_src.
// Optional stall/flush statistics counters are enabled by defining FETCH_QUEUE_STATS_EN.
module fetch_decode_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         pc_in,
  input  logic [WIDTH-1:0]         instruction_in,
  input  logic                     hit,
  input  logic                     pc_src,
  input  logic                     decode_ready,
  output logic [WIDTH-1:0]         instruction_out,
  output logic [WIDTH-1:0]         pc_out,
  output logic                     valid_out,
  output logic                     stall_fetch,
  output logic [$clog2(DEPTH):0]   count
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]              stall_cycles,
  output logic [15:0]              flush_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0] pc_mem [DEPTH];
  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [DEPTH-1:0] wr_en;
  logic             push;
  logic             pop;

  // Full/empty come from registered occupancy only, so fetch never sees decode_ready combinationally.
  assign valid_out   = (count_reg != '0);
  assign stall_fetch = (count_reg == CNT_W'(DEPTH));
  assign push        = hit & ~stall_fetch & ~pc_src;
  assign pop         = decode_ready & valid_out & ~pc_src;

  assign count           = count_reg;
  assign instruction_out = valid_out ? instr_mem[rd_ptr_reg] : '0;
  assign pc_out          = valid_out ? pc_mem[rd_ptr_reg] : '0;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push & (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  // Storage needs no reset: every read is gated by occupancy.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) begin
        pc_mem[i]    <= pc_in;
        instr_mem[i] <= instruction_in;
      end
    end
  end

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (pc_src) begin
      rd_ptr_next = wr_ptr_reg;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      if (push && !pop)      count_next = count_reg + CNT_W'(1);
      else if (pop && !push) count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stall_cycles_reg;
  logic [15:0] flush_count_reg;

  assign stall_cycles = stall_cycles_reg;
  assign flush_count  = flush_count_reg;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_reg <= '0;
      flush_count_reg  <= '0;
    end else begin
      if (stall_fetch && hit && (stall_cycles_reg != '1))
        stall_cycles_reg <= stall_cycles_reg + 32'd1;
      if (pc_src && (flush_count_reg != '1))
        flush_count_reg <= flush_count_reg + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Randomized self-checking bench for fetch_decode_queue against a queue-based model.
// Stats checks compile only when FETCH_QUEUE_STATS_EN is defined.
module tb_fetch_decode_queue;
  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] pc_in;
  logic [WIDTH-1:0] instruction_in;
  logic             hit;
  logic             pc_src;
  logic             decode_ready;
  logic [WIDTH-1:0] instruction_out;
  logic [WIDTH-1:0] pc_out;
  logic             valid_out;
  logic             stall_fetch;
  logic [2:0]       count;
`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0]      stall_cycles;
  logic [15:0]      flush_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [63:0] mq[$];
  int m_stall = 0;
  int m_flush = 0;

  always #5 clk = ~clk;

  fetch_decode_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .pc_in(pc_in),
    .instruction_in(instruction_in),
    .hit(hit),
    .pc_src(pc_src),
    .decode_ready(decode_ready),
    .instruction_out(instruction_out),
    .pc_out(pc_out),
    .valid_out(valid_out),
    .stall_fetch(stall_fetch),
    .count(count)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_count(flush_count)
`endif
  );

  task automatic drive(input logic h, input logic [31:0] pc, input logic [31:0] ins,
                       input logic src, input logic dr);
    hit = h; pc_in = pc; instruction_in = ins; pc_src = src; decode_ready = dr;
  endtask

  // Model: a plain FIFO of {pc, instr}; full/empty judged from occupancy before the edge.
  task automatic tick();
    logic [63:0] e;
    bit do_push, do_pop;
    if (rst) begin
      mq.delete();
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (hit && mq.size() == DEPTH) m_stall++;
      if (pc_src) begin
        m_flush++;
        if (mq.size() != 0) $display("flush: %0d entries dropped", mq.size());
        mq.delete();
      end else begin
        do_push = hit && (mq.size() < DEPTH);
        do_pop  = decode_ready && (mq.size() > 0);
        if (do_pop) begin
          e = mq.pop_front();
          $display("pop  pc=%08h instr=%08h", e[63:32], e[31:0]);
        end
        if (do_push) mq.push_back({pc_in, instruction_in});
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_pc();
    logic [63:0] e;
    if (mq.size() == 0) return 32'h0;
    e = mq[0];
    return e[63:32];
  endfunction

  function automatic logic [31:0] exp_instr();
    logic [63:0] e;
    if (mq.size() == 0) return 32'h0;
    e = mq[0];
    return e[31:0];
  endfunction

  task automatic test_reset();
    drive(1'b1, 32'h0, 32'h1234, 1'b0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (count !== 3'd0 || valid_out !== 1'b0 || instruction_out !== 32'h0 ||
          stall_fetch !== 1'b0 || pc_out !== 32'h0) begin
        errors++;
        $display("FAIL reset cyc%0d: count=%0d valid=%b instr=%08h stall=%b pc=%08h, required 0/0/0/0/0",
                 i, count, valid_out, instruction_out, stall_fetch, pc_out);
      end
    end
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 32'h20080001 + 32'(i), 1'b0, 1'b0);
      tick();
      checks++;
      if (count !== 3'(i + 1) || pc_out !== 32'h0 || instruction_out !== 32'h20080001) begin
        errors++;
        $display("FAIL fill push%0d: count=%0d pc=%08h instr=%08h, required %0d/00000000/20080001",
                 i, count, pc_out, instruction_out, i + 1);
      end
    end
    checks++;
    if (stall_fetch !== 1'b1) begin
      errors++;
      $display("FAIL fill stall: stall_fetch=%b, required 1", stall_fetch);
    end
    drive(1'b1, 32'h10, 32'hdeadbeef, 1'b0, 1'b0);
    tick();
    checks++;
    if (count !== 3'd4 || pc_out !== 32'h0 || count !== 3'(mq.size())) begin
      errors++;
      $display("FAIL fill overflow: count=%0d pc=%08h, required 4/00000000", count, pc_out);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (valid_out !== 1'b1 || pc_out !== 32'(i * 4) || instruction_out !== 32'h20080001 + 32'(i)) begin
        errors++;
        $display("FAIL drain%0d: valid=%b pc=%08h instr=%08h, required 1/%08h/%08h",
                 i, valid_out, pc_out, instruction_out, i * 4, 32'h20080001 + 32'(i));
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      tick();
    end
    checks++;
    if (valid_out !== 1'b0 || count !== 3'd0 || instruction_out !== 32'h0) begin
      errors++;
      $display("FAIL drain empty: valid=%b count=%0d instr=%08h, required 0/0/00000000",
               valid_out, count, instruction_out);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(i * 4), $urandom, 1'b0, 1'b1);
      tick();
      checks++;
      if (pc_out !== 32'(i * 4) || count !== 3'd1 || valid_out !== 1'b1 ||
          instruction_out !== exp_instr()) begin
        errors++;
        $display("FAIL stream%0d: pc=%08h count=%0d valid=%b instr=%08h, required %08h/1/1/%08h",
                 i, pc_out, count, valid_out, instruction_out, i * 4, exp_instr());
      end
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h200 + 32'(i * 4), $urandom, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h40, 32'h11111111, 1'b1, 1'b1);
    tick();
    checks++;
    if (count !== 3'd0 || valid_out !== 1'b0 || pc_out !== 32'h0) begin
      errors++;
      $display("FAIL flush: count=%0d valid=%b pc=%08h, required 0/0/00000000", count, valid_out, pc_out);
    end
    drive(1'b1, 32'h100, 32'h22222222, 1'b0, 1'b0);
    tick();
    checks++;
    if (pc_out !== 32'h100 || instruction_out !== 32'h22222222 || count !== 3'd1) begin
      errors++;
      $display("FAIL post-flush head: pc=%08h instr=%08h count=%0d, required 00000100/22222222/1",
               pc_out, instruction_out, count);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] second_pc;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(i * 4), $urandom, 1'b0, 1'b0);
      tick();
    end
    second_pc = 32'h304;
    drive(1'b1, 32'h30c, $urandom, 1'b0, 1'b1);
    tick();
    checks++;
    if (count !== 3'd3 || stall_fetch !== 1'b0 || pc_out !== second_pc) begin
      errors++;
      $display("FAIL push+pop at 3: count=%0d stall=%b pc=%08h, required 3/0/%08h",
               count, stall_fetch, pc_out, second_pc);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h500 + 32'(i * 4), $urandom, 1'b0, 1'b0);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    checks++;
    if (count !== 3'd0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL mid reset: count=%0d valid=%b, required 0/0", count, valid_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
      rst = 1'($urandom_range(0, 99) == 0);
      tick();
      checks++;
      if (count !== 3'(mq.size()) || valid_out !== (mq.size() != 0) ||
          stall_fetch !== (mq.size() == DEPTH) || pc_out !== exp_pc() ||
          instruction_out !== exp_instr()) begin
        errors++;
        $display("FAIL random%0d: count=%0d valid=%b stall=%b pc=%08h instr=%08h, required %0d/%b/%b/%08h/%08h",
                 i, count, valid_out, stall_fetch, pc_out, instruction_out, mq.size(),
                 mq.size() != 0, mq.size() == DEPTH, exp_pc(), exp_instr());
      end
    end
    rst = 1'b0;
  endtask

`ifdef FETCH_QUEUE_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), $urandom, 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h10, $urandom, 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      tick();
    end
    checks++;
    if (stall_cycles !== 32'(m_stall) || flush_count !== 16'(m_flush) ||
        stall_cycles !== 32'd5 || flush_count !== 16'd2) begin
      errors++;
      $display("FAIL stats: stall_cycles=%0d flush_count=%0d, required 5/2", stall_cycles, flush_count);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (stall_cycles !== 32'd0 || flush_count !== 16'd0) begin
      errors++;
      $display("FAIL stats reset: stall_cycles=%0d flush_count=%0d, required 0/0", stall_cycles, flush_count);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    test_reset();
    test_fill();
    test_stream();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef FETCH_QUEUE_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
- Small instruction queue between fetch_module and the decode stage of the MIPS pipeline.
- Captures {pc, instruction} pairs that fetch delivers on cache hit and presents them to decode in program order, first-word-fall-through.
- Back-pressures fetch when full.
- Discards all queued entries on a taken branch (pc_src) so wrong-path instructions never reach decode.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- WIDTH, 32, width of the pc and instruction fields.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- pc_in  input  WIDTH  pc of the instruction being fetched (fetch_module pc).
- instruction_in  input  WIDTH  fetched instruction (fetch_module instruction).
- hit  input  1  push request; instruction_in/pc_in are valid this cycle.
- pc_src  input  1  taken branch/jump resolved; flush the queue.
- decode_ready  input  1  decode consumes the head entry this cycle when valid_out=1.
- instruction_out  output  WIDTH  head instruction; 32'h00000000 (MIPS NOP) when empty.
- pc_out  output  WIDTH  head pc; 0 when empty.
- valid_out  output  1  queue non-empty.
- stall_fetch  output  1  queue full; fetch must hold its pc.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst=1 at a rising edge):
  - Read/write pointers and count go to 0.
  - valid_out=0, stall_fetch=0, instruction_out=0, pc_out=0.
  - rst overrides every other input.
  - Reset mid-operation drops all entries; there is no partial state.
- Storage: DEPTH-entry register array of {pc, instruction}, with circular read and write pointers of $clog2(DEPTH) bits that wrap DEPTH-1 -> 0 naturally.
- push = hit & ~stall_fetch & ~pc_src.
  - A hit while full is ignored; fetch is responsible for re-presenting it.
- pop = decode_ready & valid_out & ~pc_src.
- Push and pop in the same cycle: both pointers advance and count is unchanged.
  - This is legal at any occupancy except full, where push is blocked.
  - When empty, pop is impossible (valid_out=0), so push-only applies.
- Pop-only decrements count; push-only increments count.
- Flush (pc_src=1, rst=0):
  - Next cycle: count=0, read pointer := write pointer, valid_out=0.
  - A concurrent hit is discarded; it is wrong-path.
  - A concurrent decode_ready is ignored.
  - The first post-branch instruction is accepted in the cycle after pc_src deasserts.
- Latency: a pushed entry is visible on instruction_out/pc_out with valid_out=1 on the cycle after the push edge (1-cycle fill latency). There is no combinational path from hit to any output.
- Outputs:
  - instruction_out and pc_out are driven from the head storage entry, gated to 0 when count==0.
  - valid_out = (count!=0).
  - stall_fetch = (count==DEPTH), derived from registered state only and never from decode_ready in the same cycle. This avoids a comb loop through fetch.
- Throughput: with decode_ready held high, one instruction per cycle sustained; the queue never fills.

Optional Feature:
- Macro FETCH_QUEUE_STATS_EN.
- When defined, two extra outputs are added:
  - stall_cycles [31:0]: increments every cycle stall_fetch=1 and hit=1.
  - flush_count [15:0]: increments every cycle pc_src=1.
  - Both reset to 0 on rst and saturate at all-ones (no wrap).
- When undefined, these ports and counters do not exist and the functional behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 2 cycles with hit=1 -> count=0, valid_out=0, instruction_out=0, stall_fetch=0 throughout.
- Fill: decode_ready=0, push pcs 0x0,0x4,0x8,0xC with instructions 0x20080001..0x20080004 -> count=4, stall_fetch=1. A 5th hit with pc=0x10 is ignored. Then decode_ready=1 drains in order 0x0,0x4,0x8,0xC.
- Streaming/wrap: decode_ready=1, hit every cycle for 10 pcs 0x0..0x24 -> each pc appears on pc_out one cycle after its push, count stays 1, the pointers wrap twice with no loss or duplication.
- Flush: 3 entries queued, then pc_src=1 with hit=1 (pc=0x40) and decode_ready=1 -> next cycle count=0, valid_out=0. The 0x40 entry is absent. A hit with pc=0x100 on the following cycle appears at the head.
- Simultaneous push/pop at full-1: count=3, hit=1, decode_ready=1 -> count stays 3, head advances by one entry, stall_fetch stays 0.
- Stats (macro defined): 5 cycles of hit while full plus 2 pc_src pulses -> stall_cycles=5, flush_count=2. rst clears both to 0.
